// File: rtl/tcp_pkg.sv
// Shared constants, FSM state type and checksum helper for the TCP transmit path.
package tcp_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP   = 8'h06;
    localparam int          HDR_LEN        = 54;
    localparam int          MIN_FRAME      = 60;

    localparam logic [7:0] TCP_FIN = 8'h01;
    localparam logic [7:0] TCP_SYN = 8'h02;
    localparam logic [7:0] TCP_RST = 8'h04;
    localparam logic [7:0] TCP_PSH = 8'h08;
    localparam logic [7:0] TCP_ACK = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SUM1,
        ST_SUM2,
        ST_HDR,
        ST_PAY,
        ST_PAD
    } tx_state_t;

    // Two end-around-carry folds are enough to reduce any 32-bit sum to 16 bits.
    function automatic logic [15:0] csum_fold(input logic [31:0] s);
        logic [16:0] a;
        logic [15:0] b;
        a = {1'b0, s[15:0]} + {1'b0, s[31:16]};
        b = a[15:0] + {15'h0000, a[16]};
        return b;
    endfunction

endpackage

// File: rtl/tcp_tx_buf.sv
// Payload byte buffer: one write port and one read port, each with its own
// auto-incrementing pointer. Read data is combinational from rd_ptr.
module tcp_tx_buf #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer bookkeeping; clr rewinds both at the start of every request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array write; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/tcp_tx.sv
// Builds one Ethernet II + IPv4 + TCP segment per request. Payload is buffered
// and summed first, so both checksums are ready before the first header byte.
module tcp_tx
    import tcp_pkg::*;
#(
    parameter logic [47:0] mac         = 48'hC471FEC856BF,
    parameter logic [31:0] ip          = 32'h0AD2321E,
    parameter logic [15:0] port        = 16'd80,
    parameter logic [15:0] window      = 16'hFFFF,
    parameter logic [7:0]  ttl         = 8'd64,
    parameter int          MAX_PAYLOAD = 64,
    parameter logic [15:0] IP_ID_RESET = 16'h0000
) (
    input  logic        CLOCK,
    input  logic        RESETN,
    input  logic        start,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    input  logic [15:0] dst_port,
    input  logic [31:0] seq,
    input  logic [31:0] ack,
    input  logic [7:0]  flags,
    input  logic [10:0] payload_len,
    input  logic        inDataValid,
    input  logic [7:0]  inData,
    output logic        inReady,
    output logic        outDataValid,
    output logic [7:0]  outData,
    output logic        newpkt,
    output logic        outEop,
    output logic        busy,
    output logic        err
);

    localparam logic [10:0] LEN_MAX  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] HDR_LAST = 11'(HDR_LEN - 1);
    localparam logic [10:0] PAD_THR  = 11'(MIN_FRAME - HDR_LEN);

    tx_state_t     state;
    logic [47:0]   cur_dst_mac;
    logic [31:0]   cur_dst_ip;
    logic [15:0]   cur_dst_port;
    logic [31:0]   cur_seq;
    logic [31:0]   cur_ack;
    logic [7:0]    cur_flags;
    logic [10:0]   cur_len;
    logic [10:0]   frame_len;
    logic [10:0]   ld_cnt;
    logic [10:0]   cnt;
    logic [15:0]   ip_id;
    logic [31:0]   tcp_sum;
    logic [31:0]   ip_sum;
    logic [431:0]  hdr_sr;

    logic          accept;
    logic          reject;
    logic          buf_wr_en;
    logic          buf_rd_en;
    logic [7:0]    buf_rd_data;
    logic          last_byte;
    logic          pay_end;
    logic [15:0]   tcp_len;
    logic [15:0]   total_len;
    logic [15:0]   ip_cksum;
    logic [15:0]   tcp_cksum;
    logic [31:0]   byte_word;
    logic [31:0]   tcp_hdr_sum;
    logic [31:0]   ip_hdr_sum;

    function automatic logic [31:0] w32(input logic [15:0] x);
        return {16'h0000, x};
    endfunction

    assign accept    = (state == ST_IDLE) && start && !busy && (payload_len <= LEN_MAX);
    assign reject    = (state == ST_IDLE) && start && !busy && (payload_len > LEN_MAX);
    assign buf_wr_en = (state == ST_LOAD) && inReady && inDataValid;
    assign buf_rd_en = (state == ST_PAY);
    assign last_byte = (cnt == frame_len - 11'd1);
    assign pay_end   = (cnt == HDR_LAST + cur_len);
    assign tcp_len   = 16'd20 + {5'b00000, cur_len};
    assign total_len = 16'd40 + {5'b00000, cur_len};

    // Even payload offsets are the high byte of a 16-bit word, odd offsets the low byte.
    assign byte_word = ld_cnt[0] ? {24'h000000, inData} : {16'h0000, inData, 8'h00};

    // Pseudo-header plus TCP header with the checksum and urgent fields at zero.
    assign tcp_hdr_sum = w32(ip[31:16]) + w32(ip[15:0])
                       + w32(cur_dst_ip[31:16]) + w32(cur_dst_ip[15:0])
                       + w32({8'h00, IP_PROTO_TCP}) + w32(tcp_len)
                       + w32(port) + w32(cur_dst_port)
                       + w32(cur_seq[31:16]) + w32(cur_seq[15:0])
                       + w32(cur_ack[31:16]) + w32(cur_ack[15:0])
                       + w32({8'h50, cur_flags}) + w32(window);

    assign ip_hdr_sum = w32(16'h4500) + w32(total_len) + w32(ip_id) + w32(16'h4000)
                      + w32({ttl, IP_PROTO_TCP})
                      + w32(ip[31:16]) + w32(ip[15:0])
                      + w32(cur_dst_ip[31:16]) + w32(cur_dst_ip[15:0]);

    assign ip_cksum  = ~csum_fold(ip_sum);
    assign tcp_cksum = ~csum_fold(tcp_sum);

    tcp_tx_buf #(
        .DEPTH(MAX_PAYLOAD)
    ) u_buf (
        .clk    (CLOCK),
        .resetn (RESETN),
        .clr    (accept),
        .wr_en  (buf_wr_en),
        .wr_data(inData),
        .rd_en  (buf_rd_en),
        .rd_data(buf_rd_data)
    );

    // Datapath: capture request fields, accumulate checksums, build and shift the header.
    always_ff @(posedge CLOCK) begin
        if (accept) begin
            cur_dst_mac  <= dst_mac;
            cur_dst_ip   <= dst_ip;
            cur_dst_port <= dst_port;
            cur_seq      <= seq;
            cur_ack      <= ack;
            cur_flags    <= flags;
            cur_len      <= payload_len;
            frame_len    <= (payload_len < PAD_THR) ? 11'(MIN_FRAME) : payload_len + 11'(HDR_LEN);
            tcp_sum      <= 32'h0;
        end
        case (state)
            ST_LOAD: if (buf_wr_en) tcp_sum <= tcp_sum + byte_word;
            ST_SUM1: begin
                tcp_sum <= tcp_sum + tcp_hdr_sum;
                ip_sum  <= ip_hdr_sum;
            end
            ST_SUM2: hdr_sr <= {cur_dst_mac, mac, ETHERTYPE_IPV4,
                                8'h45, 8'h00, total_len, ip_id, 16'h4000, ttl, IP_PROTO_TCP,
                                ip_cksum, ip, cur_dst_ip,
                                port, cur_dst_port, cur_seq, cur_ack, 8'h50, cur_flags,
                                window, tcp_cksum, 16'h0000};
            ST_HDR:  hdr_sr <= {hdr_sr[423:0], 8'h00};
            default: ;
        endcase
    end

    // Control FSM with registered outputs; one frame byte per cycle once emitting.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state        <= ST_IDLE;
            inReady      <= 1'b0;
            outDataValid <= 1'b0;
            outData      <= 8'h00;
            newpkt       <= 1'b0;
            outEop       <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            ip_id        <= IP_ID_RESET;
            ld_cnt       <= 11'd0;
            cnt          <= 11'd0;
        end else begin
            err <= reject;
            case (state)
                ST_IDLE: begin
                    outDataValid <= 1'b0;
                    outData      <= 8'h00;
                    newpkt       <= 1'b0;
                    outEop       <= 1'b0;
                    busy         <= 1'b0;
                    if (accept) begin
                        busy   <= 1'b1;
                        ld_cnt <= 11'd0;
                        cnt    <= 11'd0;
                        if (payload_len == 11'd0) begin
                            state <= ST_SUM1;
                        end else begin
                            state   <= ST_LOAD;
                            inReady <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (buf_wr_en) begin
                        ld_cnt <= ld_cnt + 11'd1;
                        if (ld_cnt == cur_len - 11'd1) begin
                            inReady <= 1'b0;
                            state   <= ST_SUM1;
                        end
                    end
                end
                ST_SUM1: state <= ST_SUM2;
                ST_SUM2: state <= ST_HDR;
                ST_HDR, ST_PAY, ST_PAD: begin
                    outDataValid <= 1'b1;
                    newpkt       <= (cnt == 11'd0);
                    outEop       <= last_byte;
                    cnt          <= cnt + 11'd1;
                    if (state == ST_HDR)      outData <= hdr_sr[431:424];
                    else if (state == ST_PAY) outData <= buf_rd_data;
                    else                      outData <= 8'h00;
                    if (last_byte) begin
                        state <= ST_IDLE;
                        ip_id <= ip_id + 16'd1;
                    end else if (state == ST_HDR && cnt == HDR_LAST) begin
                        state <= (cur_len == 11'd0) ? ST_PAD : ST_PAY;
                    end else if (state == ST_PAY && pay_end) begin
                        state <= ST_PAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_tx.sv
// Randomized scoreboard bench for tcp_tx: a byte-list reference model builds each
// expected frame; a separate monitor compares every emitted byte and framing flag.
module tb_tcp_tx;
    import tcp_pkg::*;

    localparam logic [47:0] LMAC  = 48'hC471FEC856BF;
    localparam logic [31:0] LIP   = 32'h0AD2321E;
    localparam logic [15:0] LPORT = 16'd80;
    localparam logic [15:0] LWIN  = 16'hFFFF;
    localparam logic [7:0]  LTTL  = 8'd64;

    logic        CLOCK;
    logic        RESETN;
    logic        start;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [10:0] payload_len;
    logic        inDataValid;
    logic [7:0]  inData;
    logic        inReady, outDataValid, newpkt, outEop, busy, err;
    logic [7:0]  outData;
    logic        w_inReady, w_outDataValid, w_newpkt, w_outEop, w_busy, w_err;
    logic [7:0]  w_outData;

    tcp_tx dut (
        .CLOCK(CLOCK), .RESETN(RESETN), .start(start), .dst_mac(dst_mac), .dst_ip(dst_ip),
        .dst_port(dst_port), .seq(seq), .ack(ack), .flags(flags), .payload_len(payload_len),
        .inDataValid(inDataValid), .inData(inData), .inReady(inReady),
        .outDataValid(outDataValid), .outData(outData), .newpkt(newpkt), .outEop(outEop),
        .busy(busy), .err(err)
    );

    // Second instance whose identification counter starts at 0xFFFF, to see the wrap.
    tcp_tx #(.IP_ID_RESET(16'hFFFF)) dut_wrap (
        .CLOCK(CLOCK), .RESETN(RESETN), .start(start), .dst_mac(dst_mac), .dst_ip(dst_ip),
        .dst_port(dst_port), .seq(seq), .ack(ack), .flags(flags), .payload_len(payload_len),
        .inDataValid(inDataValid), .inData(inData), .inReady(w_inReady),
        .outDataValid(w_outDataValid), .outData(w_outData), .newpkt(w_newpkt), .outEop(w_outEop),
        .busy(w_busy), .err(w_err)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int mon_idx = 0;

    logic [7:0]  fb[$];
    logic [7:0]  exp_bytes[$];
    int          exp_lens[$];
    logic [15:0] exp_ids[$];
    int          exp_np[$];
    logic [7:0]  pay_buf [0:1499];
    logic [15:0] exp_id = 16'h0000;

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        forever begin
            @(posedge CLOCK);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic void put8(input logic [7:0] b);
        fb.push_back(b);
    endfunction

    function automatic void put16(input logic [15:0] v);
        put8(v[15:8]);
        put8(v[7:0]);
    endfunction

    function automatic void put32(input logic [31:0] v);
        put16(v[31:16]);
        put16(v[15:0]);
    endfunction

    // Internet checksum over fb[from +: n], big-endian words, odd tail padded with zero.
    function automatic logic [15:0] cksum(input logic [31:0] init, input int from, input int n);
        logic [31:0] s;
        logic [31:0] hi;
        logic [31:0] lo;
        s = init;
        for (int i = 0; i < n; i += 2) begin
            hi = 32'(fb[from + i]);
            lo = (i + 1 < n) ? 32'(fb[from + i + 1]) : 32'h0;
            s = s + hi * 256 + lo;
        end
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic push_frame(input logic [47:0] dm, input logic [31:0] di, input logic [15:0] dp,
                              input logic [31:0] sq, input logic [31:0] ak, input logic [7:0] fl,
                              input int n, input logic [15:0] id);
        logic [15:0] c;
        logic [31:0] ph;
        fb.delete();
        put16(dm[47:32]); put32(dm[31:0]);
        put16(LMAC[47:32]); put32(LMAC[31:0]);
        put16(16'h0800);
        put8(8'h45); put8(8'h00); put16(16'(40 + n)); put16(id); put16(16'h4000);
        put8(LTTL); put8(8'h06); put16(16'h0000); put32(LIP); put32(di);
        put16(LPORT); put16(dp); put32(sq); put32(ak); put8(8'h50); put8(fl);
        put16(LWIN); put16(16'h0000); put16(16'h0000);
        for (int i = 0; i < n; i++) put8(pay_buf[i]);
        c = cksum(32'h0, 14, 20);
        fb[24] = c[15:8];
        fb[25] = c[7:0];
        ph = 32'(LIP[31:16]) + 32'(LIP[15:0]) + 32'(di[31:16]) + 32'(di[15:0])
           + 32'd6 + 32'(20 + n);
        c = cksum(ph, 34, 20 + n);
        fb[50] = c[15:8];
        fb[51] = c[7:0];
        while (fb.size() < 60) put8(8'h00);
        foreach (fb[i]) exp_bytes.push_back(fb[i]);
        exp_lens.push_back(fb.size());
        exp_ids.push_back(id);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy) begin
            @(negedge CLOCK);
            t++;
            if (t > 3000) begin
                checks++;
                fails++;
                $display("FAIL idle_timeout got=busy want=idle");
                return;
            end
        end
    endtask

    task automatic send(input logic [47:0] dm, input logic [31:0] di, input logic [15:0] dp,
                        input logic [31:0] sq, input logic [31:0] ak, input logic [7:0] fl,
                        input int n, input bit gaps);
        int acc;
        int t;
        logic rdy;
        wait_idle();
        push_frame(dm, di, dp, sq, ak, fl, n, exp_id);
        exp_id = exp_id + 16'd1;
        start = 1'b1;
        dst_mac = dm; dst_ip = di; dst_port = dp; seq = sq; ack = ak; flags = fl;
        payload_len = 11'(n);
        @(negedge CLOCK);
        start = 1'b0;
        acc = cyc;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                inDataValid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge CLOCK);
            end
            inDataValid = 1'b1;
            inData = pay_buf[i];
            t = 0;
            do begin
                rdy = inReady;
                @(negedge CLOCK);
                t++;
            end while (!rdy && t < 100);
            if (!rdy) begin
                checks++;
                fails++;
                $display("FAIL load_timeout got=not_ready want=ready");
                break;
            end
            acc = cyc;
        end
        inDataValid = 1'b0;
        exp_np.push_back(acc + 3);
    endtask

    // Monitor: pops expected bytes as the DUT emits them; flushes a frame cut by reset.
    initial begin
        logic [7:0]  want;
        logic [15:0] wid;
        int          len;
        int          npc;
        forever begin
            @(negedge CLOCK);
            if (!RESETN) begin
                if (mon_idx > 0) begin
                    len = exp_lens.pop_front();
                    for (int k = mon_idx; k < len; k++) want = exp_bytes.pop_front();
                    wid = exp_ids.pop_front();
                    mon_idx = 0;
                end
            end else if (outDataValid) begin
                if (exp_lens.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_byte got=%0h want=none", outData);
                end else begin
                    len  = exp_lens[0];
                    want = exp_bytes.pop_front();
                    chk($sformatf("byte%0d", mon_idx), 32'(outData), 32'(want));
                    chk("newpkt", 32'(newpkt), 32'(mon_idx == 0));
                    chk("outEop", 32'(outEop), 32'(mon_idx == len - 1));
                    if (mon_idx == 0) begin
                        if (exp_np.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL latency got=newpkt want=no_frame_pending");
                        end else begin
                            npc = exp_np.pop_front();
                            chk("latency", 32'(cyc), 32'(npc));
                        end
                    end
                    if (mon_idx == 18 || mon_idx == 19) begin
                        wid = exp_ids[0] + 16'hFFFF;
                        chk("wrap_ip_id", 32'(w_outData), 32'((mon_idx == 18) ? wid[15:8] : wid[7:0]));
                    end
                    if (mon_idx == len - 1) begin
                        len = exp_lens.pop_front();
                        wid = exp_ids.pop_front();
                        mon_idx = 0;
                    end else begin
                        mon_idx++;
                    end
                end
            end else if (mon_idx > 0) begin
                checks++;
                fails++;
                $display("FAIL gap got=valid_low want=valid_high at byte %0d", mon_idx);
            end
        end
    end

    initial begin
        logic [47:0] dm;
        logic [31:0] di;
        int t;
        int n;
        start = 1'b0; dst_mac = '0; dst_ip = '0; dst_port = '0; seq = '0; ack = '0;
        flags = '0; payload_len = '0; inDataValid = 1'b0; inData = '0;
        RESETN = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESETN = 1'b1;
        @(negedge CLOCK);
        chk("rst_inReady", 32'(inReady), 32'h0);
        chk("rst_outDataValid", 32'(outDataValid), 32'h0);
        chk("rst_outData", 32'(outData), 32'h0);
        chk("rst_newpkt", 32'(newpkt), 32'h0);
        chk("rst_outEop", 32'(outEop), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // SYN-ACK with no payload, then a one-byte payload back to back.
        send(48'h001122334455, 32'h0AD2321C, 16'd57284, 32'h00001000, 32'h12345679,
             TCP_SYN | TCP_ACK, 0, 1'b0);
        pay_buf[0] = 8'h20;
        send(48'h001122334455, 32'h0AD2321C, 16'd57284, 32'h00001001, 32'h12345679,
             TCP_PSH | TCP_ACK, 1, 1'b0);

        // A start while the frame is in flight is ignored without err.
        chk("busy_in_flight", 32'(busy), 32'h1);
        start = 1'b1;
        payload_len = 11'd3;
        @(negedge CLOCK);
        start = 1'b0;
        chk("ignored_start_err", 32'(err), 32'h0);

        // Full-size payload with random input gaps.
        for (int i = 0; i < 64; i++) pay_buf[i] = 8'(i);
        send(48'h0A0B0C0D0E0F, 32'hC0A80001, 16'd1234, 32'hDEADBEEF, 32'h01020304,
             TCP_ACK, 64, 1'b1);

        // Oversize request is rejected.
        wait_idle();
        start = 1'b1;
        payload_len = 11'd65;
        @(negedge CLOCK);
        start = 1'b0;
        chk("reject_err", 32'(err), 32'h1);
        chk("reject_busy", 32'(busy), 32'h0);
        @(negedge CLOCK);
        chk("reject_err_pulse", 32'(err), 32'h0);
        chk("reject_busy_after", 32'(busy), 32'h0);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            dm = {16'($urandom), $urandom};
            di = $urandom;
            n  = $urandom_range(0, 64);
            for (int i = 0; i < n; i++) pay_buf[i] = 8'($urandom);
            send(dm, di, 16'($urandom), $urandom, $urandom, 8'($urandom), n, f[0]);
        end

        // Reset in the middle of the header truncates the frame.
        for (int i = 0; i < 10; i++) pay_buf[i] = 8'($urandom);
        send(48'h665544332211, 32'h0A000001, 16'd443, 32'h11111111, 32'h22222222,
             TCP_ACK, 10, 1'b0);
        t = 0;
        while (mon_idx < 20 && t < 500) begin
            @(negedge CLOCK);
            t++;
        end
        if (mon_idx < 20) begin
            checks++;
            fails++;
            $display("FAIL hdr_wait got=%0d want=20", mon_idx);
        end
        @(posedge CLOCK);
        #2;
        RESETN = 1'b0;
        #1;
        chk("arst_outDataValid", 32'(outDataValid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_outEop", 32'(outEop), 32'h0);
        chk("arst_newpkt", 32'(newpkt), 32'h0);
        repeat (2) @(negedge CLOCK);
        RESETN = 1'b1;
        exp_id = 16'h0000;
        @(negedge CLOCK);
        for (int i = 0; i < 12; i++) pay_buf[i] = 8'(8'hA0 + i);
        send(48'h665544332211, 32'h0A000001, 16'd443, 32'h33333333, 32'h44444444,
             TCP_FIN | TCP_ACK, 12, 1'b1);

        t = 0;
        while ((exp_lens.size() > 0 || busy) && t < 2000) begin
            @(negedge CLOCK);
            t++;
        end
        repeat (3) @(negedge CLOCK);
        chk("frames_left", 32'(exp_lens.size()), 32'h0);
        chk("newpkt_left", 32'(exp_np.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/tcp_tx.md
Name: tcp_tx

Overview:
- Transmit-side companion to the Tcp receiver. Builds one complete Ethernet II + IPv4 + TCP segment per request.
- Emits it as a byte stream using the same outDataValid/outData/newpkt-style signalling the receiver and PcapParser consume, so frames can be looped straight back into Tcp.
- Payload (0..MAX_PAYLOAD bytes) is buffered first, so both the IPv4 and TCP checksums are known before the first header byte leaves.
- No FCS is emitted.

Parameters:
- mac, 48'hC471FEC856BF, local (source) MAC address.
- ip, 32'h0AD2321E, local (source) IPv4 address, 10.210.50.30.
- port, 80, local TCP source port.
- window, 16'hFFFF, advertised TCP window.
- ttl, 8'd64, IPv4 TTL.
- MAX_PAYLOAD, 64, payload buffer depth in bytes. Maximum 1460.

Ports:
- CLOCK  in  1  sole clock, rising edge.
- RESETN  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request. Header fields below are sampled on the accepting edge.
- dst_mac  in  48  destination MAC.
- dst_ip  in  32  destination IPv4.
- dst_port  in  16  destination TCP port.
- seq  in  32  TCP sequence number.
- ack  in  32  TCP acknowledgement number.
- flags  in  8  TCP flags byte (e.g. 0x12 = SYN+ACK).
- payload_len  in  11  payload byte count.
- inDataValid  in  1  payload byte valid.
- inData  in  8  payload byte.
- inReady  out  1  payload byte accepted on an edge where inDataValid && inReady.
- outDataValid  out  1  outData valid.
- outData  out  8  frame byte.
- newpkt  out  1  high with the first frame byte only.
- outEop  out  1  high with the last frame byte only.
- busy  out  1  high from the accepting edge until the cycle after outEop.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: all outputs 0, state IDLE, ip_id counter 0.
- Reset mid-frame truncates the frame immediately. No outEop is emitted; buffer contents are discarded.
- States and transitions:
  - IDLE → LOAD when start && payload_len in 1..MAX_PAYLOAD.
  - IDLE → SUM when start && payload_len==0.
  - start && payload_len>MAX_PAYLOAD: err=1 for one cycle, stay IDLE.
  - start while busy is ignored. No err.
  - LOAD: inReady=1. Each accepted byte is written to the buffer at wr_ptr and added to the TCP sum. Even-offset bytes count as the high byte of a 16-bit word, odd-offset bytes as the low byte. LOAD → SUM on acceptance of byte payload_len-1. Input gaps simply extend LOAD.
  - SUM, 2 cycles:
    - Cycle 1: add the pseudo-header and TCP header words to the sum. Pseudo-header is src ip, dst ip, 0x0006, tcp_len = 20+payload_len. Header is taken with checksum=0. Compute the IPv4 header sum in parallel.
    - Cycle 2: fold carries twice into 16 bits and one's-complement both checksums.
  - HDR: 54 bytes, one per cycle, outDataValid=1, newpkt on byte 0. Byte order:
    - Bytes 0-13, Ethernet: dst_mac, mac, 0x0800.
    - Bytes 14-33, IPv4: 0x45, 0x00, total_len = 40+payload_len, ip_id, 0x4000 (DF), ttl, 0x06, ip_cksum, ip, dst_ip.
    - Bytes 34-53, TCP: port, dst_port, seq, ack, 0x50, flags, window, tcp_cksum, 0x0000.
  - PAY: payload_len bytes read from the buffer in order.
  - PAD: zero bytes until the frame is 60 bytes long. Padding is included in neither checksum.
  - Final byte carries outEop; next state is IDLE and ip_id increments, wrapping at 16'hFFFF→0.
- outDataValid is contiguous from newpkt to outEop. There is no output backpressure.
- Latency: newpkt asserts on the 3rd rising edge after the edge that accepted the last payload byte, or after the accepting start edge when payload_len==0.
- Frame length = max(60, 54+payload_len).
- Widths: checksum accumulators are 32-bit, so no overflow is possible for MAX_PAYLOAD ≤ 1460.

Decomposition:
- Shared package tcp_pkg:
  - Constants: ETHERTYPE_IPV4, IP_PROTO_TCP, HDR_LEN=54, MIN_FRAME=60, TCP flag bit constants (FIN, SYN, RST, PSH, ACK).
  - Function: csum_fold(32→16).
- One sub-module, tcp_tx_buf: MAX_PAYLOAD×8 single-port-write / single-port-read RAM with wr_ptr/rd_ptr counters. Same component intended for later reuse by the receiver.

Test Plan:
- SYN-ACK: flags 0x12, payload_len 0, dst 10.210.50.28:57284, seq 0x00001000, ack 0x12345679.
  - Expect 60 bytes; IPv4 total_len 0x0028; bytes 54-59 = 0x00.
  - Both checksums match the bench reference model; frame fed through Tcp loops back cleanly.
- 1-byte payload 0x20:
  - Expect 60 bytes; total_len 0x0029; byte 54=0x20; bytes 55-59 = 0.
  - TCP checksum computed with 0x2000 as the final word.
- payload_len 64, bytes 0x00..0x3F with random inDataValid gaps:
  - Expect a 118-byte frame and contiguous outDataValid.
  - newpkt exactly 3 cycles after the last accepted byte; bytes 54..117 = 0x00..0x3F.
- Rejection: payload_len 65 → err pulse, busy stays 0, no output. start pulsed while busy → ignored, exactly one frame out.
- Back-to-back frames: ip_id reads 0x0000 then 0x0001. Preload ip_id to 0xFFFF and check it wraps to 0x0000.
- RESETN low at HDR byte 20:
  - outDataValid/busy drop asynchronously; no outEop.
  - A new start after reset produces a correct full frame with ip_id 0.
